// File: rtl/e20_state_dumper_if.sv
// Output stream of the E20 end-of-run state dumper.
// Carries one 16-bit architectural-state word per valid/ready handshake,
// tagged with its source (pc, register, memory) and marked on the final word.
interface e20_state_dumper_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_tag;
  logic        out_last;

  // Dumper side drives the word, consumer side drives the back-pressure.
  modport master (
    output out_valid,
    output out_data,
    output out_tag,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_tag,
    input  out_last,
    output out_ready
  );
endinterface : e20_state_dumper_if

// File: rtl/e20_state_dumper.sv
// E20 end-of-run state dumper.
// On a rising edge of start (processor halt) it snapshots the pc, then walks
// $0..$(NUM_REGS-1) and RAM words 0..DUMP_WORDS-1, emitting each as one word on
// the output stream, in the same order as the software simulator's final print.
// Register file and RAM are assumed frozen while busy; only the pc is latched.
module e20_state_dumper #(
  parameter int MEM_ADDR_W = 13,
  parameter int NUM_REGS   = 8,
  parameter int DUMP_WORDS = 128
) (
  input  logic                  clock,
  input  logic                  reset,       // active-low, asynchronous
  input  logic                  start,
  input  logic [15:0]           pc_in,
  output logic [2:0]            reg_addr,
  input  logic [15:0]           reg_data,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [15:0]           mem_rd_data,
  e20_state_dumper_if.master    out_if,
  output logic                  busy,
  output logic                  done
);

  // Memory index is one bit wider than needed so the last index is representable
  // with headroom; the loop stops at DUMP_WORDS-1 so it never wraps.
  localparam int K_W = $clog2(DUMP_WORDS) + 1;

  localparam logic [1:0]     TAG_PC    = 2'd0;
  localparam logic [1:0]     TAG_REG   = 2'd1;
  localparam logic [1:0]     TAG_MEM   = 2'd2;
  localparam logic [2:0]     LAST_REG  = 3'(NUM_REGS - 1);
  localparam logic [K_W-1:0] LAST_WORD = K_W'(DUMP_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PC,
    S_REG,
    S_MEM_RD,
    S_MEM_CAP
  } state_e;

  state_e         state_q,   state_d;
  logic           start_q,   start_d;
  logic [15:0]    data_q,    data_d;
  logic [1:0]     tag_q,     tag_d;
  logic           last_q,    last_d;
  logic           valid_q,   valid_d;
  logic [2:0]     reg_idx_q, reg_idx_d;
  logic [K_W-1:0] k_q,       k_d;
  logic           fresh_q,   fresh_d;
  logic           done_q,    done_d;

  logic handshake;
  logic trigger;

  assign handshake = valid_q && out_if.out_ready;
  assign trigger   = start && !start_q;

  // State register: every flop clears asynchronously so the stream disappears
  // the moment reset is asserted, even mid-dump.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together
  // from the same pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      data_q    <= '0;
      tag_q     <= TAG_PC;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      reg_idx_q <= '0;
      k_q       <= '0;
      fresh_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      reg_idx_q <= reg_idx_d;
      k_q       <= k_d;
      fresh_q   <= fresh_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: walks pc -> registers -> memory, advancing only on handshake.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missing default in always_comb infers a latch.
  always_comb begin
    state_d   = state_q;
    start_d   = start;
    data_d    = data_q;
    tag_d     = tag_q;
    last_d    = last_q;
    valid_d   = valid_q;
    reg_idx_d = reg_idx_q;
    k_d       = k_q;
    fresh_d   = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Only a 0->1 transition starts a dump; a held-high start is ignored.
        if (trigger) begin
          data_d  = pc_in;
          tag_d   = TAG_PC;
          last_d  = 1'b0;
          valid_d = 1'b1;
          state_d = S_PC;
        end
      end

      S_PC: begin
        // reg_addr is 0 here, so reg_data already holds $0.
        if (handshake) begin
          data_d    = reg_data;
          tag_d     = TAG_REG;
          reg_idx_d = '0;
          state_d   = S_REG;
        end
      end

      S_REG: begin
        // reg_addr points at the next register so it can be loaded in the
        // same cycle the current one is accepted.
        if (handshake) begin
          if (reg_idx_q != LAST_REG) begin
            data_d    = reg_data;
            reg_idx_d = reg_idx_q + 3'd1;
          end else begin
            valid_d = 1'b0;
            k_d     = '0;
            state_d = S_MEM_RD;
          end
        end
      end

      S_MEM_RD: begin
        // Read strobe is issued this cycle; data arrives in the next one.
        valid_d = 1'b1;
        tag_d   = TAG_MEM;
        last_d  = (k_q == LAST_WORD);
        fresh_d = 1'b1;
        state_d = S_MEM_CAP;
      end

      S_MEM_CAP: begin
        // RAM data is only valid in the first capture cycle; hold a copy for stalls.
        if (fresh_q) begin
          data_d = mem_rd_data;
        end
        if (handshake) begin
          valid_d = 1'b0;
          if (last_q) begin
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            k_d     = k_q + K_W'(1);
            state_d = S_MEM_RD;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // In the first memory-capture cycle the word is forwarded straight from the
  // RAM so it appears without an extra cycle of latency.
  assign out_if.out_data  = fresh_q ? mem_rd_data : data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_tag   = tag_q;
  assign out_if.out_last  = last_q;

  assign reg_addr  = (state_q == S_REG) ? (reg_idx_q + 3'd1) : 3'd0;
  assign mem_rd_en = (state_q == S_MEM_RD);
  assign mem_addr  = MEM_ADDR_W'(k_q);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule : e20_state_dumper

// File: tb/tb_e20_state_dumper.sv
// Self-checking bench for e20_state_dumper: random register/RAM contents and
// back-pressure, compared against the expected dump list built from the arrays.
module tb_e20_state_dumper;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] pc_in;
  logic [2:0]  reg_addr;
  logic [15:0] reg_data;
  logic        mem_rd_en;
  logic [12:0] mem_addr;
  logic [15:0] mem_rd_data;
  logic        busy;
  logic        done;

  e20_state_dumper_if dif ();

  e20_state_dumper #(
    .MEM_ADDR_W(13),
    .NUM_REGS  (8),
    .DUMP_WORDS(128)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .pc_in      (pc_in),
    .reg_addr   (reg_addr),
    .reg_data   (reg_data),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .out_if     (dif.master),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [15:0] d;
    logic [1:0]  t;
    logic        l;
    int          c;
  } word_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          bp       = 0;
  logic [15:0] regs [8];
  logic [15:0] ram  [128];
  int          rd_count = 0;
  int          rd_bad   = 0;
  int          rd_hits  [128];
  word_t       got [$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  bit          stall_prev = 0;
  logic [18:0] prev_w = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  assign reg_data = regs[reg_addr];

  // RAM model: data valid only in the cycle after the strobe, garbage otherwise.
  always @(posedge clock) begin
    if (mem_rd_en) begin
      rd_count++;
      if (mem_addr < 13'd128) begin
        rd_hits[mem_addr[6:0]]++;
        mem_rd_data <= ram[mem_addr[6:0]];
      end else begin
        rd_bad++;
        mem_rd_data <= 16'($urandom);
      end
    end else begin
      mem_rd_data <= 16'($urandom);
    end
  end

  // Consumer back-pressure, changed just after each active edge.
  initial begin
    dif.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      dif.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Stream monitor: collects accepted words and checks stability during stalls.
  always @(negedge clock) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", 32'({dif.out_valid, dif.out_data, dif.out_tag, dif.out_last}),
              32'({1'b1, prev_w}));
      if (dif.out_valid && dif.out_ready)
        got.push_back('{dif.out_data, dif.out_tag, dif.out_last, cyc});
      stall_prev = dif.out_valid && !dif.out_ready;
      prev_w     = {dif.out_data, dif.out_tag, dif.out_last};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic trigger(output int t0);
    @(posedge clock);
    #1;
    got.delete();
    start = 1'b1;
    t0    = cyc;
  endtask

  task automatic wait_done(input int base, input int limit);
    int n = 0;
    while (done_cnt == base && n < limit) begin
      @(posedge clock);
      n++;
    end
    check("done_seen", 32'(done_cnt > base), 32'd1);
  endtask

  // Expected dump: pc, then every register, then RAM 0..127, with the cycle
  // at which each word is presented when the consumer is always ready.
  task automatic compare_stream(input string nm, input logic [15:0] pc_exp,
                                input int t0, input bit timing);
    word_t exp [$];
    exp.push_back('{pc_exp, 2'd0, 1'b0, t0 + 1});
    for (int i = 0; i < 8; i++) exp.push_back('{regs[i], 2'd1, 1'b0, t0 + 2 + i});
    for (int k = 0; k < 128; k++) exp.push_back('{ram[k], 2'd2, 1'(k == 127), t0 + 11 + 2 * k});
    check({nm, "_count"}, 32'(got.size()), 32'd137);
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s_word%0d", nm, i), 32'({got[i].d, got[i].t, got[i].l}),
            32'({exp[i].d, exp[i].t, exp[i].l}));
      if (timing)
        check($sformatf("%s_cycle%0d", nm, i), 32'(got[i].c - t0), 32'(exp[i].c - t0));
    end
    if (timing) check({nm, "_done_cycle"}, 32'(done_cyc - t0), 32'd266);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int base;
    int hit_errs;
    logic [15:0] pc_val;

    reset = 1'b0;
    start = 1'b0;
    pc_in = 16'h0005;
    mem_rd_data = '0;
    for (int i = 0; i < 128; i++) rd_hits[i] = 0;
    regs[0] = 16'h0000;
    regs[1] = 16'h0003;
    regs[2] = 16'hFFFF;
    for (int i = 3; i < 8; i++) regs[i] = 16'($urandom);
    for (int k = 0; k < 128; k++) ram[k] = 16'($urandom);
    ram[0]   = 16'h8001;
    ram[127] = 16'hBEEF;

    // Reset state
    tick(3);
    check("reset_outputs", 32'({dif.out_valid, dif.out_data, dif.out_tag, dif.out_last,
                                busy, done, mem_rd_en}), 32'd0);
    check("reset_addrs", 32'({mem_addr, reg_addr}), 32'd0);
    reset = 1'b1;
    tick(2);

    // 1: basic dump with consumer always ready
    base = done_cnt;
    trigger(t0);
    tick(1);
    start = 1'b0;
    wait_done(base, 1000);
    compare_stream("basic", 16'h0005, t0, 1'b1);
    tick(5);
    check("basic_done_once", 32'(done_cnt - base), 32'd1);

    // 2: random back-pressure
    bp = 1'b1;
    base = done_cnt;
    trigger(t0);
    tick(1);
    start = 1'b0;
    wait_done(base, 3000);
    tick(20);
    compare_stream("bp", 16'h0005, t0, 1'b0);
    check("bp_done_once", 32'(done_cnt - base), 32'd1);
    bp = 1'b0;
    tick(2);

    // 3: start held high -> one dump; re-arm; pulse while busy ignored
    base = done_cnt;
    trigger(t0);
    tick(1000);
    check("hold_done_once", 32'(done_cnt - base), 32'd1);
    compare_stream("hold", 16'h0005, t0, 1'b1);
    start = 1'b0;
    tick(2);
    base = done_cnt;
    trigger(t0);
    tick(1);
    start = 1'b0;
    tick(50);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(base, 1000);
    tick(300);
    check("retrig_done_once", 32'(done_cnt - base), 32'd1);
    compare_stream("retrig", 16'h0005, t0, 1'b1);

    // 4: reset while RAM word 60 is pending
    base = done_cnt;
    trigger(t0);
    tick(1);
    start = 1'b0;
    while (cyc < t0 + 131) tick(1);
    check("pending_word60", 32'({dif.out_valid, dif.out_tag, dif.out_data}),
          32'({1'b1, 2'd2, ram[60]}));
    #1;
    reset = 1'b0;
    #1;
    check("reset_drop", 32'({dif.out_valid, busy, done, mem_rd_en}), 32'd0);
    tick(5);
    check("reset_no_done", 32'(done_cnt - base), 32'd0);
    reset = 1'b1;
    tick(2);
    base = done_cnt;
    trigger(t0);
    tick(1);
    start = 1'b0;
    wait_done(base, 1000);
    compare_stream("after_rst", 16'h0005, t0, 1'b1);

    // 5: pc changes after the trigger
    base = done_cnt;
    trigger(t0);
    tick(1);
    start = 1'b0;
    tick(2);
    pc_in = 16'h1234;
    wait_done(base, 1000);
    compare_stream("pc_snap", 16'h0005, t0, 1'b1);

    // 6: RAM latency with address-derived pattern
    for (int k = 0; k < 128; k++) ram[k] = 16'(k) ^ 16'hA5A5;
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
    pc_val = 16'($urandom);
    pc_in  = pc_val;
    tick(2);
    rd_count = 0;
    rd_bad   = 0;
    for (int i = 0; i < 128; i++) rd_hits[i] = 0;
    base = done_cnt;
    trigger(t0);
    tick(1);
    start = 1'b0;
    wait_done(base, 1000);
    tick(5);
    compare_stream("ramlat", pc_val, t0, 1'b1);
    check("rd_en_count", 32'(rd_count), 32'd128);
    check("rd_addr_range", 32'(rd_bad), 32'd0);
    hit_errs = 0;
    for (int i = 0; i < 128; i++) if (rd_hits[i] != 1) hit_errs++;
    check("rd_once_per_addr", 32'(hit_errs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_e20_state_dumper
